// File: rtl/rv32i_types.sv
// Shared RV32I front-end types.
//   fetch_reg_1_t  : request metadata registered by fetch_1 while an imem read is in flight
//   iq_entry_t     : one instruction-queue entry {inst, pc, branch_pred}
//   fetch2_state_t : fetch_2 squash FSM states
package rv32i_types;

  typedef struct packed {
    logic [31:0] pc;
    logic        valid;
    logic        branch_pred;
  } fetch_reg_1_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        branch_pred;
  } iq_entry_t;

  typedef enum logic {
    RUN    = 1'b0,
    SQUASH = 1'b1
  } fetch2_state_t;

  // Pair a returning instruction word with the metadata of its request.
  function automatic iq_entry_t make_iq_entry(input logic [31:0] inst,
                                              input fetch_reg_1_t req);
    iq_entry_t e;
    e.inst        = inst;
    e.pc          = req.pc;
    e.branch_pred = req.branch_pred;
    return e;
  endfunction

endpackage

// File: rtl/iq_fifo.sv
// Instruction queue storage: DEPTH-entry FIFO of iq_entry_t.
// Synchronous write, asynchronous read of the head entry.
// Ports:
//   clk, rst        clock, asynchronous active-high reset (pointers only)
//   flush           clears head/tail pointers on the next edge; overrides wr_en/rd_en
//   wr_en, wr_data  push one entry (ignored when full)
//   rd_en           pop the head entry (ignored when empty)
//   rd_data         head entry (undefined content when empty)
//   count           number of occupied entries, 0..DEPTH
//   full, empty     occupancy flags decoded from the pointers
module iq_fifo
  import rv32i_types::*;
#(
  parameter int DEPTH = 16,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             wr_en,
  input  iq_entry_t        wr_data,
  input  logic             rd_en,
  output iq_entry_t        rd_data,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty
);

  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
  iq_entry_t      mem_q [DEPTH];
  logic           wr_fire;
  logic           rd_fire;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign count = wr_ptr_q - rd_ptr_q;

  assign wr_fire = wr_en && !full  && !flush;
  assign rd_fire = rd_en && !empty && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_fire) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_fire) rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage is data only; it needs no reset because the head outputs
  // are masked whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_ptr_q[PTR_W-1:0]] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q[PTR_W-1:0]];

endmodule

// File: rtl/fetch_2.sv
// Second fetch stage: pairs imem responses with the in-flight request metadata,
// buffers them in the instruction queue and hands them to decode.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   branch_mispredict    backend flush (one cycle)
//   imem_resp/imem_rdata instruction-memory response
//   fetch_1_reg          metadata of the request currently in flight
//   queue_full           backpressure to fetch_1 (count >= DEPTH-1)
//   iq_valid/iq_ready    decode handshake for the head entry
//   iq_inst/iq_pc/iq_branch_pred  head entry, zero when the queue is empty
module fetch_2
  import rv32i_types::*;
#(
  parameter int DEPTH = 16,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         branch_mispredict,
  input  logic         imem_resp,
  input  logic [31:0]  imem_rdata,
  input  fetch_reg_1_t fetch_1_reg,
  output logic         queue_full,
  output logic         iq_valid,
  input  logic         iq_ready,
  output logic [31:0]  iq_inst,
  output logic [31:0]  iq_pc,
  output logic         iq_branch_pred
);

  localparam logic [PTR_W:0] DEPTH_C  = DEPTH[PTR_W:0];
  localparam logic [PTR_W:0] FULL_THR = DEPTH_C - 1'b1;

  fetch2_state_t  state_q, state_d;
  logic           enq_attempt;
  logic           enq_en;
  logic           deq_en;
  logic [PTR_W:0] iq_count;
  logic           fifo_full;
  logic           fifo_empty;
  iq_entry_t      head;

  // Squash FSM. When a mispredict lands while a request is still outstanding,
  // that request's response belongs to the wrong path and must be eaten when
  // it returns. If the response arrives in the mispredict cycle itself it is
  // dropped by the enqueue qualification instead and no squash is needed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (branch_mispredict && fetch_1_reg.valid && !imem_resp) state_d = SQUASH;
      end
      SQUASH: begin
        if (imem_resp) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  assign enq_attempt = imem_resp && fetch_1_reg.valid && (state_q == RUN) &&
                       !branch_mispredict;
  assign enq_en      = enq_attempt && !fifo_full;
  assign deq_en      = iq_valid && iq_ready && !branch_mispredict;

  iq_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_iq_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (branch_mispredict),
    .wr_en   (enq_en),
    .wr_data (make_iq_entry(imem_rdata, fetch_1_reg)),
    .rd_en   (deq_en),
    .rd_data (head),
    .count   (iq_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // All outputs decode registered state only; no input reaches an output.
  assign iq_valid       = !fifo_empty;
  assign queue_full     = (iq_count >= FULL_THR);
  assign iq_inst        = iq_valid ? head.inst        : 32'h0;
  assign iq_pc          = iq_valid ? head.pc          : 32'h0;
  assign iq_branch_pred = iq_valid ? head.branch_pred : 1'b0;

  // queue_full leaves one slot for the single in-flight response, so a
  // response arriving with the queue completely full means fetch_1 ignored
  // backpressure.
  a_no_enq_when_full : assert property (
    @(posedge clk) disable iff (rst) !(enq_attempt && (iq_count == DEPTH_C))
  );

endmodule
